mult_client: RTL and testbench

Initiator-side driver for the `multiplier` block. It generates a run of 2**LOGDEPTH operand pairs and feeds them through the `EN_mult`/`RDY_mult` handshake. It then issues `EN_blockRead`, collects the product stream on `VALID_memVal`/`memVal_data`, and checks every word against a locally computed expected product. It sits between the control/test harness (start, bases, result readout) and the multiplier's command and readback ports.

---
 rtl/mult_client.sv | 152 +++++++++++++++
 tb/tb_mult_client.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_client.sv
// mult_client: initiator for the multiplier block. Streams 2**LOGDEPTH operand pairs
// through the EN_mult/RDY_mult handshake, requests block readback, and checks every
// returned word against a locally computed product while accumulating a running sum.
module mult_client #(
  parameter int unsigned LOGDEPTH = 6,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [15:0]         a_base,
  input  logic [15:0]         b_base,
  output logic                EN_mult,
  output logic [15:0]         mult_input0,
  output logic [15:0]         mult_input1,
  input  logic                RDY_mult,
  output logic                EN_blockRead,
  input  logic                VALID_memVal,
  input  logic [WIDTH-1:0]    memVal_data,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    sum,
  output logic [LOGDEPTH:0]   mismatch_cnt,
  output logic                timeout
);

  localparam int unsigned Depth = 2 ** LOGDEPTH;
  localparam int unsigned CntW  = LOGDEPTH + 1;
  localparam logic [LOGDEPTH-1:0] LastIdx     = LOGDEPTH'(Depth - 1);
  localparam logic [LOGDEPTH:0]   MisMax      = CntW'(Depth);
  localparam logic [7:0]          TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StFill, StReq, StRead, StDone} state_e;

  state_e              state_q;
  logic [15:0]         a_q, b_q;
  logic [15:0]         op0_q, op1_q;
  logic [LOGDEPTH-1:0] idx_q;
  logic [7:0]          tcnt_q;
  logic                en_mult_q, en_read_q, busy_q, done_q, timeout_q;
  logic [WIDTH-1:0]    sum_q;
  logic [LOGDEPTH:0]   mis_q;

  logic [15:0]         exp0, exp1;
  logic [31:0]         exp_prod;
  logic [WIDTH-1:0]    exp_word;

  // Expected product for the word currently being read (idx_q counts read words in REQ/READ).
  always_comb begin
    exp0     = a_q + 16'(idx_q);
    exp1     = b_q + 16'(idx_q);
    exp_prod = 32'(exp0) * 32'(exp1);
    exp_word = WIDTH'(exp_prod);
  end

  // Run sequencer: fill, request, read/check, done; all outputs registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      op0_q     <= '0;
      op1_q     <= '0;
      idx_q     <= '0;
      tcnt_q    <= '0;
      en_mult_q <= 1'b0;
      en_read_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      sum_q     <= '0;
      mis_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q       <= a_base;
            b_q       <= b_base;
            op0_q     <= a_base;
            op1_q     <= b_base;
            idx_q     <= '0;
            sum_q     <= '0;
            mis_q     <= '0;
            timeout_q <= 1'b0;
            en_mult_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= StFill;
          end
        end
        StFill: begin
          if (RDY_mult) begin
            if (idx_q == LastIdx) begin
              // Hand over straight to the readback request without a bubble.
              en_mult_q <= 1'b0;
              en_read_q <= 1'b1;
              idx_q     <= '0;
              tcnt_q    <= '0;
              state_q   <= StReq;
            end else begin
              idx_q <= idx_q + 1'b1;
              op0_q <= op0_q + 16'd1;
              op1_q <= op1_q + 16'd1;
            end
          end
        end
        StReq, StRead: begin
          if (VALID_memVal) begin
            sum_q     <= sum_q + memVal_data;
            tcnt_q    <= '0;
            en_read_q <= 1'b0;
            if (memVal_data != exp_word && mis_q != MisMax) begin
              mis_q <= mis_q + 1'b1;
            end
            if (idx_q == LastIdx) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StRead;
            end
          end else if (tcnt_q == TimeoutLast) begin
            // Abort: partial sum and mismatch count are kept as they are.
            timeout_q <= 1'b1;
            en_read_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign EN_mult      = en_mult_q;
  assign mult_input0  = op0_q;
  assign mult_input1  = op1_q;
  assign EN_blockRead = en_read_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sum          = sum_q;
  assign mismatch_cnt = mis_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_mult_client.sv
// tb_mult_client: drives mult_client against a behavioural multiplier and checks results
// against products and sums computed directly from the operand rules.
module tb_mult_client;

  localparam int unsigned LOGDEPTH = 6;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned TIMEOUT  = 255;
  localparam int          Depth    = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [15:0]       a_base, b_base;
  logic              EN_mult;
  logic [15:0]       mult_input0, mult_input1;
  logic              RDY_mult;
  logic              EN_blockRead;
  logic              VALID_memVal;
  logic [WIDTH-1:0]  memVal_data;
  logic              busy, done;
  logic [WIDTH-1:0]  sum;
  logic [LOGDEPTH:0] mismatch_cnt;
  logic              timeout;

  int total = 0;
  int bad   = 0;

  logic [15:0] acc_a[$], acc_b[$], stall_a[$], stall_b[$];
  int          fill_cycles;
  bit          busy_at_done;
  bit          req_held;

  mult_client #(.LOGDEPTH(LOGDEPTH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .a_base       (a_base),
    .b_base       (b_base),
    .EN_mult      (EN_mult),
    .mult_input0  (mult_input0),
    .mult_input1  (mult_input1),
    .RDY_mult     (RDY_mult),
    .EN_blockRead (EN_blockRead),
    .VALID_memVal (VALID_memVal),
    .memVal_data  (memVal_data),
    .busy         (busy),
    .done         (done),
    .sum          (sum),
    .mismatch_cnt (mismatch_cnt),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  // Reference: word k is (a+k mod 2^16) * (b+k mod 2^16) as a 32-bit product.
  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input int k);
    logic [15:0] x, y;
    x = a + 16'(k);
    y = b + 16'(k);
    return {16'h0, x} * {16'h0, y};
  endfunction

  function automatic logic [31:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                          input logic [63:0] cmask);
    logic [31:0] s;
    s = 32'h0;
    for (int k = 0; k < Depth; k++) s = s + (ref_prod(a, b, k) ^ {31'h0, cmask[k]});
    return s;
  endfunction

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic do_start(input logic [15:0] a, input logic [15:0] b);
    a_base = a;
    b_base = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    a_base = 16'($urandom);
    b_base = 16'($urandom);
  endtask

  // Behavioural multiplier command side: records every accepted pair.
  task automatic do_fill(input int stall_at, input int stall_len, input bit rand_rdy,
                         input int stop_at, input bit noise);
    int  stall_left;
    bit  rdy;
    stall_left  = stall_len;
    fill_cycles = 0;
    acc_a.delete(); acc_b.delete(); stall_a.delete(); stall_b.delete();
    while (EN_mult && fill_cycles < 2000) begin
      if (stop_at >= 0 && acc_a.size() == stop_at) break;
      if (stall_at >= 0 && acc_a.size() == stall_at && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
        stall_a.push_back(mult_input0);
        stall_b.push_back(mult_input1);
      end else if (rand_rdy) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else begin
        rdy = 1'b1;
      end
      RDY_mult = rdy;
      if (rdy) begin
        acc_a.push_back(mult_input0);
        acc_b.push_back(mult_input1);
      end
      if (noise) begin
        start  = 1'($urandom_range(0, 1));
        a_base = 16'($urandom);
        b_base = 16'($urandom);
      end
      @(posedge clk); #1;
      fill_cycles++;
    end
    RDY_mult = 1'b0;
    start    = 1'b0;
  endtask

  // Behavioural multiplier readback side: returns the products of the accepted pairs.
  task automatic do_read(input bit gaps, input bit never, input logic [63:0] cmask,
                         input bit start_at_done, output int cyc, output int done_cnt);
    int k;
    bit started;
    k = 0; cyc = 0; started = 1'b0; done_cnt = 0;
    req_held = 1'b1; busy_at_done = 1'b0;
    while (cyc < 2000) begin
      if (done) break;
      if (started && k == 0 && !EN_blockRead) req_held = 1'b0;
      if (EN_blockRead) started = 1'b1;
      if (!never && started && k < acc_a.size() && (!gaps || $urandom_range(0, 2) != 0)) begin
        VALID_memVal = 1'b1;
        memVal_data  = ({16'h0, acc_a[k]} * {16'h0, acc_b[k]}) ^ {31'h0, cmask[k]};
        k++;
      end else begin
        VALID_memVal = 1'b0;
        memVal_data  = $urandom;
      end
      @(posedge clk); #1;
      cyc++;
    end
    VALID_memVal = 1'b0;
    if (done) begin
      done_cnt++;
      busy_at_done = busy;
    end
    start = start_at_done;
    @(posedge clk); #1;
    start = 1'b0;
    if (done) done_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a_base = '0; b_base = '0;
    RDY_mult = 1'b0; VALID_memVal = 1'b0; memVal_data = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({EN_mult, EN_blockRead, busy, done, timeout} !== 5'b0 || sum !== '0 ||
        mismatch_cnt !== '0 || mult_input0 !== '0 || mult_input1 !== '0) begin
      bad++;
      $display("FAIL reset_outputs: en=%b rd=%b busy=%b done=%b to=%b sum=%0d mis=%0d, want all 0",
               EN_mult, EN_blockRead, busy, done, timeout, sum, mismatch_cnt);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({EN_mult, EN_blockRead, busy} !== 3'b0) begin
      bad++;
      $display("FAIL reset_release: en=%b rd=%b busy=%b, want 000", EN_mult, EN_blockRead, busy);
    end
  endtask

  task automatic test_basic();
    int cyc, dcnt, pbad;
    do_start(16'h0, 16'h0);
    total++;
    if ({EN_mult, busy, mult_input0, mult_input1} !== {2'b11, 32'h0}) begin
      bad++;
      $display("FAIL basic_start: en=%b busy=%b ops=(%0d,%0d), want en=1 busy=1 ops=(0,0)",
               EN_mult, busy, mult_input0, mult_input1);
    end
    do_fill(-1, 0, 1'b0, -1, 1'b0);
    total++;
    if (acc_a.size() !== Depth || fill_cycles !== Depth) begin
      bad++;
      $display("FAIL basic_fill: accepts=%0d cycles=%0d, want 64/64", acc_a.size(), fill_cycles);
    end
    total++;
    if ({EN_mult, EN_blockRead} !== 2'b01) begin
      bad++;
      $display("FAIL basic_handover: en=%b rd=%b, want 0 1", EN_mult, EN_blockRead);
    end
    pbad = 0;
    for (int k = 0; k < acc_a.size(); k++)
      if (acc_a[k] !== 16'(k) || acc_b[k] !== 16'(k)) pbad++;
    total++;
    if (pbad != 0) begin
      bad++;
      $display("FAIL basic_operands: %0d wrong pairs, want 0", pbad);
    end
    do_read(1'b0, 1'b0, 64'h0, 1'b1, cyc, dcnt);
    total++;
    if (sum !== 32'd85344 || sum !== ref_sum(16'h0, 16'h0, 64'h0)) begin
      bad++;
      $display("FAIL basic_sum: got %0d, want %0d", sum, ref_sum(16'h0, 16'h0, 64'h0));
    end
    total++;
    if (mismatch_cnt !== '0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL basic_status: mis=%0d to=%b, want 0 0", mismatch_cnt, timeout);
    end
    total++;
    if (dcnt !== 1 || busy_at_done !== 1'b1) begin
      bad++;
      $display("FAIL basic_done: pulses=%0d busy_at_done=%b, want 1 1", dcnt, busy_at_done);
    end
    // start was held high during the DONE cycle and must have been ignored
    total++;
    if ({busy, EN_mult} !== 2'b00) begin
      bad++;
      $display("FAIL start_at_done: busy=%b en=%b, want 0 0", busy, EN_mult);
    end
  endtask

  task automatic test_stall();
    int cyc, dcnt, pbad;
    do_start(16'h0, 16'h0);
    do_fill(10, 3, 1'b0, -1, 1'b0);
    pbad = 0;
    for (int i = 0; i < stall_a.size(); i++)
      if (stall_a[i] !== 16'd10 || stall_b[i] !== 16'd10) pbad++;
    total++;
    if (stall_a.size() !== 3 || pbad != 0) begin
      bad++;
      $display("FAIL stall_hold: stall cycles=%0d bad=%0d, want 3 cycles at (10,10)",
               stall_a.size(), pbad);
    end
    pbad = 0;
    for (int k = 0; k < acc_a.size(); k++)
      if (acc_a[k] !== 16'(k) || acc_b[k] !== 16'(k)) pbad++;
    total++;
    if (acc_a.size() !== Depth || pbad != 0 || fill_cycles !== Depth + 3) begin
      bad++;
      $display("FAIL stall_accepts: accepts=%0d bad=%0d cycles=%0d, want 64 0 67",
               acc_a.size(), pbad, fill_cycles);
    end
    do_read(1'b0, 1'b0, 64'h0, 1'b0, cyc, dcnt);
    total++;
    if (mismatch_cnt !== '0 || dcnt !== 1) begin
      bad++;
      $display("FAIL stall_result: mis=%0d pulses=%0d, want 0 1", mismatch_cnt, dcnt);
    end
  endtask

  task automatic test_corrupt(input logic [63:0] cmask, input int want_mis);
    int cyc, dcnt;
    logic [15:0] a, b;
    a = 16'($urandom);
    b = 16'($urandom);
    do_start(a, b);
    do_fill(-1, 0, 1'b1, -1, 1'b1);
    do_read(1'b1, 1'b0, cmask, 1'b0, cyc, dcnt);
    total++;
    if (mismatch_cnt !== 7'(want_mis)) begin
      bad++;
      $display("FAIL corrupt_mis: got %0d, want %0d", mismatch_cnt, want_mis);
    end
    total++;
    if (sum !== ref_sum(a, b, cmask) || dcnt !== 1) begin
      bad++;
      $display("FAIL corrupt_sum: sum=%h pulses=%0d, want %h 1", sum, dcnt, ref_sum(a, b, cmask));
    end
  endtask

  task automatic test_timeout();
    int cyc, dcnt;
    do_start(16'($urandom), 16'($urandom));
    do_fill(-1, 0, 1'b0, -1, 1'b0);
    do_read(1'b0, 1'b1, 64'h0, 1'b0, cyc, dcnt);
    total++;
    if (cyc !== TIMEOUT || req_held !== 1'b1) begin
      bad++;
      $display("FAIL timeout_latency: done after %0d cycles req_held=%b, want %0d 1",
               cyc, req_held, TIMEOUT);
    end
    total++;
    if (timeout !== 1'b1 || mismatch_cnt !== '0 || sum !== '0 || dcnt !== 1) begin
      bad++;
      $display("FAIL timeout_status: to=%b mis=%0d sum=%0d pulses=%0d, want 1 0 0 1",
               timeout, mismatch_cnt, sum, dcnt);
    end
    total++;
    if (EN_blockRead !== 1'b0) begin
      bad++;
      $display("FAIL timeout_release: rd=%b, want 0", EN_blockRead);
    end
  endtask

  task automatic test_wrap();
    int cyc, dcnt;
    logic [31:0] w0, w1, want;
    do_start(16'hFFFF, 16'h0002);
    do_fill(-1, 0, 1'b0, -1, 1'b0);
    w0 = {16'h0, acc_a[0]} * {16'h0, acc_b[0]};
    w1 = {16'h0, acc_a[1]} * {16'h0, acc_b[1]};
    total++;
    if (acc_a[1] !== 16'h0 || acc_b[1] !== 16'h3 || w0 !== 32'h0001FFFE || w1 !== 32'h0) begin
      bad++;
      $display("FAIL wrap_operands: idx1=(%h,%h) w0=%h w1=%h, want (0,3) 0001fffe 0",
               acc_a[1], acc_b[1], w0, w1);
    end
    do_read(1'b1, 1'b0, 64'h0, 1'b0, cyc, dcnt);
    want = ref_sum(16'hFFFF, 16'h0002, 64'h0);
    total++;
    if (mismatch_cnt !== '0 || sum !== want) begin
      bad++;
      $display("FAIL wrap_result: mis=%0d sum=%h, want 0 %h", mismatch_cnt, sum, want);
    end
    // Stray readback data while idle must not touch the held results
    for (int i = 0; i < 5; i++) begin
      VALID_memVal = 1'b1;
      memVal_data  = $urandom;
      @(posedge clk); #1;
    end
    VALID_memVal = 1'b0;
    total++;
    if (sum !== want || mismatch_cnt !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_valid: sum=%h mis=%0d busy=%b, want %h 0 0", sum, mismatch_cnt, busy, want);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, dcnt, quiet_bad;
    logic [15:0] a, b;
    do_start(16'($urandom), 16'($urandom));
    do_fill(-1, 0, 1'b0, 20, 1'b0);
    total++;
    if (acc_a.size() !== 20 || EN_mult !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_reach: accepts=%0d en=%b, want 20 1", acc_a.size(), EN_mult);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({EN_mult, busy, EN_blockRead} !== 3'b000) begin
      bad++;
      $display("FAIL rstmid_async: en=%b busy=%b rd=%b, want 000", EN_mult, busy, EN_blockRead);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    quiet_bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if ({EN_mult, EN_blockRead, busy} !== 3'b000) quiet_bad++;
    end
    total++;
    if (quiet_bad != 0) begin
      bad++;
      $display("FAIL rstmid_quiet: %0d cycles with residual activity, want 0", quiet_bad);
    end
    a = 16'($urandom);
    b = 16'($urandom);
    do_start(a, b);
    do_fill(-1, 0, 1'b1, -1, 1'b0);
    do_read(1'b1, 1'b0, 64'h0, 1'b0, cyc, dcnt);
    total++;
    if (acc_a.size() !== Depth || mismatch_cnt !== '0 || sum !== ref_sum(a, b, 64'h0)) begin
      bad++;
      $display("FAIL rstmid_rerun: accepts=%0d mis=%0d sum=%h, want 64 0 %h",
               acc_a.size(), mismatch_cnt, sum, ref_sum(a, b, 64'h0));
    end
  endtask

  task automatic test_random();
    int cyc, dcnt, pbad;
    logic [15:0] a, b;
    for (int r = 0; r < 3; r++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      do_start(a, b);
      do_fill(-1, 0, 1'b1, -1, 1'b1);
      pbad = 0;
      for (int k = 0; k < acc_a.size(); k++)
        if (acc_a[k] !== 16'(a + 16'(k)) || acc_b[k] !== 16'(b + 16'(k))) pbad++;
      total++;
      if (acc_a.size() !== Depth || pbad != 0) begin
        bad++;
        $display("FAIL random_operands: run %0d accepts=%0d bad=%0d, want 64 0",
                 r, acc_a.size(), pbad);
      end
      do_read(1'b1, 1'b0, 64'h0, 1'b0, cyc, dcnt);
      total++;
      if (sum !== ref_sum(a, b, 64'h0) || mismatch_cnt !== '0 || timeout !== 1'b0 || dcnt !== 1) begin
        bad++;
        $display("FAIL random_result: run %0d sum=%h mis=%0d to=%b pulses=%0d, want %h 0 0 1",
                 r, sum, mismatch_cnt, timeout, dcnt, ref_sum(a, b, 64'h0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_corrupt((64'h1 << 5) | (64'h1 << 40), 2);
    test_timeout();
    test_wrap();
    test_reset_mid();
    test_random();
    test_corrupt({64{1'b1}}, Depth);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
